i2c_reg_arbiter: RTL and testbench

I2C_REG_ARBITER -- requirements
Module: i2c_reg_arbiter

---
 rtl/i2c_reg_arbiter.sv | 112 +++++++++++
 tb/tb_i2c_reg_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_arbiter.sv
// Small register file shared by an I2C-side requester and a local requester.
// A three-state FSM grants one side at a time, using round-robin tie-breaking.
// The top address is a read-only ID register. Register 0 is exported as ctrl_out.
module i2c_reg_arbiter #(
  parameter int                ADDR_W = 3,
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] ID_VAL = 8'hA5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i2c_req,
  input  logic              i2c_we,
  input  logic [ADDR_W-1:0] i2c_addr,
  input  logic [DATA_W-1:0] i2c_wdata,
  output logic              i2c_ack,
  output logic [DATA_W-1:0] i2c_rdata,
  input  logic              loc_req,
  input  logic              loc_we,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [DATA_W-1:0] loc_wdata,
  output logic              loc_ack,
  output logic [DATA_W-1:0] loc_rdata,
  output logic [DATA_W-1:0] ctrl_out,
  output logic              busy
);

  localparam int                NREG     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    ACK
  } state_t;

  state_t            state;
  logic              last_loc;   // 1: the local side won the previous grant
  logic              win_loc;    // 1: the current transaction belongs to the local side
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] regs [NREG];
  logic              grant_loc;
  logic [DATA_W-1:0] rd_val;

  // Pick the winner. A lone request always wins. On a tie, grant the side not granted last.
  assign grant_loc = loc_req && (!i2c_req || !last_loc);

  // Read mux. The top address reads the fixed ID, not the storage behind it.
  assign rd_val    = (lat_addr == TOP_ADDR) ? ID_VAL : regs[lat_addr];

  assign ctrl_out  = regs[0];

  // Arbitration FSM, register file and all registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      last_loc  <= 1'b1;
      win_loc   <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      i2c_ack   <= 1'b0;
      loc_ack   <= 1'b0;
      i2c_rdata <= '0;
      loc_rdata <= '0;
      busy      <= 1'b0;
      // NOTE: the register file is tiny and must come up as zero, so reset it here.
      // Large RAMs are normally left unreset so that they map onto memory macros.
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      // NOTE: only non-blocking assignments here. Every read in this block
      // then sees the value from before the clock edge, whatever the statement order.
      i2c_ack <= 1'b0;
      loc_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (i2c_req || loc_req) begin
            win_loc   <= grant_loc;
            lat_we    <= grant_loc ? loc_we    : i2c_we;
            lat_addr  <= grant_loc ? loc_addr  : i2c_addr;
            lat_wdata <= grant_loc ? loc_wdata : i2c_wdata;
            busy      <= 1'b1;
            state     <= SERVE;
          end
        end
        SERVE: begin
          if (lat_we) begin
            if (lat_addr != TOP_ADDR) regs[lat_addr] <= lat_wdata;
          end else if (win_loc) begin
            loc_rdata <= rd_val;
          end else begin
            i2c_rdata <= rd_val;
          end
          state <= ACK;
        end
        ACK: begin
          if (win_loc) loc_ack <= 1'b1;
          else         i2c_ack <= 1'b1;
          last_loc <= win_loc;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// Bench for i2c_reg_arbiter. It uses directed transactions.
// A transaction-level model predicts every output on every clock cycle.
// Literal checks pin the key scenarios by hand.
module tb_i2c_reg_arbiter;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       i2c_req = 1'b0, i2c_we = 1'b0;
  logic [2:0] i2c_addr = '0;
  logic [7:0] i2c_wdata = '0;
  logic       i2c_ack;
  logic [7:0] i2c_rdata;
  logic       loc_req = 1'b0, loc_we = 1'b0;
  logic [2:0] loc_addr = '0;
  logic [7:0] loc_wdata = '0;
  logic       loc_ack;
  logic [7:0] loc_rdata;
  logic [7:0] ctrl_out;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  i2c_reg_arbiter #(.ADDR_W(3), .DATA_W(8), .ID_VAL(8'hA5)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .i2c_req  (i2c_req),
    .i2c_we   (i2c_we),
    .i2c_addr (i2c_addr),
    .i2c_wdata(i2c_wdata),
    .i2c_ack  (i2c_ack),
    .i2c_rdata(i2c_rdata),
    .loc_req  (loc_req),
    .loc_we   (loc_we),
    .loc_addr (loc_addr),
    .loc_wdata(loc_wdata),
    .loc_ack  (loc_ack),
    .loc_rdata(loc_rdata),
    .ctrl_out (ctrl_out),
    .busy     (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model.
  // A grant is taken at an edge where the arbiter is free.
  // Its effect lands one edge later, and its ack appears two edges later.
  // The arbiter is free again after the ack edge.
  localparam int LAT = 3;
  logic [7:0] m_mem [8] = '{default: 8'h00};
  logic       m_last_loc = 1'b1;
  logic       m_i2c_ack = 1'b0, m_loc_ack = 1'b0;
  logic [7:0] m_i2c_rd = 8'h00, m_loc_rd = 8'h00;
  bit         m_pend = 1'b0;
  int         m_t_acc = 0;
  int         m_edge = 0;
  logic       m_loc, m_we;
  logic [2:0] m_addr;
  logic [7:0] m_wdata;

  function automatic logic [7:0] m_read(input logic [2:0] a);
    return (a == 3'd7) ? 8'hA5 : m_mem[a];
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
      m_last_loc = 1'b1;
      m_i2c_ack  = 1'b0;
      m_loc_ack  = 1'b0;
      m_i2c_rd   = 8'h00;
      m_loc_rd   = 8'h00;
      m_pend     = 1'b0;
    end else begin
      m_edge++;
      m_i2c_ack = 1'b0;
      m_loc_ack = 1'b0;
      if (m_pend && m_edge == m_t_acc + 1) begin
        if (m_we) begin
          if (m_addr != 3'd7) m_mem[m_addr] = m_wdata;
        end else if (m_loc) m_loc_rd = m_read(m_addr);
        else                m_i2c_rd = m_read(m_addr);
      end
      if (m_pend && m_edge == m_t_acc + LAT - 1) begin
        if (m_loc) m_loc_ack = 1'b1;
        else       m_i2c_ack = 1'b1;
        m_last_loc = m_loc;
        m_pend     = 1'b0;
      end else if (!m_pend && (i2c_req || loc_req)) begin
        m_loc   = (i2c_req && loc_req) ? !m_last_loc : loc_req;
        m_we    = m_loc ? loc_we    : i2c_we;
        m_addr  = m_loc ? loc_addr  : i2c_addr;
        m_wdata = m_loc ? loc_wdata : i2c_wdata;
        m_t_acc = m_edge;
        m_pend  = 1'b1;
      end
    end
  end

  // Compare every DUT output against the model on each falling edge while out of reset.
  always @(negedge clock) begin
    if (reset_n) begin
      check("i2c_ack",   i2c_ack,   m_i2c_ack);
      check("loc_ack",   loc_ack,   m_loc_ack);
      check("i2c_rdata", i2c_rdata, m_i2c_rd);
      check("loc_rdata", loc_rdata, m_loc_rd);
      check("ctrl_out",  ctrl_out,  m_mem[0]);
      check("busy",      busy,      m_pend);
      check("ack_excl",  i2c_ack & loc_ack, 1'b0);
    end
  end

  // Run one transaction on one side. Hold req until ack, then drop it.
  // Return the number of rising edges from request to ack.
  task automatic txn(input bit side_loc, input bit we, input logic [2:0] a,
                     input logic [7:0] d, output int lat);
    bit got;
    @(negedge clock);
    if (side_loc) begin
      loc_req = 1'b1; loc_we = we; loc_addr = a; loc_wdata = d;
    end else begin
      i2c_req = 1'b1; i2c_we = we; i2c_addr = a; i2c_wdata = d;
    end
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      got = side_loc ? loc_ack : i2c_ack;
    end
    check("txn_ack_seen", got, 1'b1);
    if (side_loc) loc_req = 1'b0;
    else          i2c_req = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 20 && !idle; i++) begin
      @(negedge clock);
      idle = !busy && !i2c_ack && !loc_ack;
    end
    check("idle_reached", idle, 1'b1);
  endtask

  initial begin
    int lat;
    int first_ack;
    int acks;
    int cyc;
    bit q [$];

    // Both sides request from reset and keep requesting.
    i2c_req = 1'b1; i2c_we = 1'b0; i2c_addr = 3'd7;
    loc_req = 1'b1; loc_we = 1'b0; loc_addr = 3'd1;
    #22 reset_n = 1'b1;
    first_ack = -1;
    cyc = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
      if (i2c_ack) q.push_back(1'b0);
      if (loc_ack) q.push_back(1'b1);
      if ((i2c_ack || loc_ack) && first_ack < 0) first_ack = cyc;
    end
    i2c_req = 1'b0;
    loc_req = 1'b0;
    check("tie_first_lat", first_ack, 3);
    check("tie_count", q.size(), 4);
    if (q.size() >= 3) begin
      check("tie_grant0_i2c", q[0], 1'b0);
      check("tie_grant1_loc", q[1], 1'b1);
      check("tie_grant2_i2c", q[2], 1'b0);
    end
    wait_idle();
    check("tie_i2c_rdata_id", i2c_rdata, 8'hA5);

    // I2C writes 0x01 to register 0.
    txn(1'b0, 1'b1, 3'd0, 8'h01, lat);
    check("wr0_latency", lat, 3);
    check("wr0_ctrl_out", ctrl_out, 8'h01);

    // The ID register reads back its fixed value and ignores writes.
    txn(1'b1, 1'b0, 3'd7, 8'h00, lat);
    check("id_read", loc_rdata, 8'hA5);
    txn(1'b1, 1'b1, 3'd7, 8'h00, lat);
    txn(1'b1, 1'b0, 3'd7, 8'h00, lat);
    check("id_read_after_wr", loc_rdata, 8'hA5);

    // Data written from the I2C side is visible to the local side.
    txn(1'b0, 1'b1, 3'd3, 8'h5C, lat);
    txn(1'b1, 1'b0, 3'd3, 8'h00, lat);
    check("xside_loc_rdata", loc_rdata, 8'h5C);
    check("xside_i2c_rdata", i2c_rdata, 8'hA5);

    // Reset pulsed during SERVE of a write of 0xFF to register 0.
    @(negedge clock);
    i2c_req = 1'b1; i2c_we = 1'b1; i2c_addr = 3'd0; i2c_wdata = 8'hFF;
    @(posedge clock);
    @(negedge clock);
    #1 reset_n = 1'b0;
    i2c_req = 1'b0;
    #2 reset_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      acks += int'(i2c_ack) + int'(loc_ack);
    end
    check("rst_no_ack", acks, 0);
    check("rst_ctrl_out", ctrl_out, 8'h00);
    check("rst_busy", busy, 1'b0);
    txn(1'b0, 1'b1, 3'd0, 8'h02, lat);
    check("rst_next_lat", lat, 3);
    check("rst_next_ctrl", ctrl_out, 8'h02);

    // The I2C request is dropped during SERVE, but the transaction still completes.
    @(negedge clock);
    i2c_req = 1'b1; i2c_we = 1'b1; i2c_addr = 3'd2; i2c_wdata = 8'h33;
    @(posedge clock);
    @(negedge clock);
    i2c_req = 1'b0;
    i2c_addr = 3'd5;
    i2c_wdata = 8'h00;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      acks += int'(i2c_ack);
    end
    check("drop_one_ack", acks, 1);
    check("drop_busy", busy, 1'b0);
    txn(1'b1, 1'b0, 3'd2, 8'h00, lat);
    check("drop_data", loc_rdata, 8'h33);

    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
